id_issue_stage: RTL

- Parametrised decode-to-execute issue stage: operand forwarding from NUM_FWD sources with fixed priority, multi-cycle load-use interlock via a shift scoreboard, valid/ready backpressure in both directions, and flush.
- Sits between the instruction decoder output and the ID/EX pipeline register consumer.
- Decoded control fields are carried as an opaque CTRL_W-bit packet.
- Generalises the single-cycle load hold and two-source forwarding to configurable depth, source count and downstream stalls.

---
 rtl/id_issue_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/id_issue_stage.sv
// Decode-to-execute issue stage. It forwards operands from prioritised
// sources and runs a load-use interlock through a shift scoreboard.
// It handles valid/ready backpressure on both sides and flush.
module id_issue_stage #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned CTRL_W   = 128,
  parameter int unsigned NUM_FWD  = 3,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [REG_AW-1:0]         in_rs1,
  input  logic [REG_AW-1:0]         in_rs2,
  input  logic                      in_uses_rs1,
  input  logic                      in_uses_rs2,
  input  logic [REG_AW-1:0]         in_rd,
  input  logic                      in_wb,
  input  logic                      in_is_load,
  input  logic [XLEN-1:0]           rf_rs1_data,
  input  logic [XLEN-1:0]           rf_rs2_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_wb,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [XLEN-1:0]           out_rs1_val,
  output logic [XLEN-1:0]           out_rs2_val,
  output logic [REG_AW-1:0]         out_rd,
  output logic                      out_wb,
  output logic [31:0]               stall_cycles
);

  localparam int unsigned SB_N = LOAD_LAT;

  // Scoreboard slots: slot 0 is the youngest in-flight load.
  logic              sb_vld_q [SB_N];
  logic [REG_AW-1:0] sb_rd_q  [SB_N];
  logic              sb_vld_d [SB_N];
  logic [REG_AW-1:0] sb_rd_d  [SB_N];

  logic              out_valid_q;
  logic [XLEN-1:0]   out_pc_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [XLEN-1:0]   out_rs1_q;
  logic [XLEN-1:0]   out_rs2_q;
  logic [REG_AW-1:0] out_rd_q;
  logic              out_wb_q;
  logic [31:0]       stall_q;
  logic [31:0]       stall_d;

  logic            advance_c;
  logic            rs1_busy_c;
  logic            rs2_busy_c;
  logic            hazard_c;
  logic            fire_c;
  logic [XLEN-1:0] rs1_fwd_c;
  logic [XLEN-1:0] rs2_fwd_c;

  // Handshake: the output slot can take a new entry when it is empty or being drained.
  assign advance_c = ~out_valid_q | out_ready;
  assign hazard_c  = in_valid & ((in_uses_rs1 & rs1_busy_c) | (in_uses_rs2 & rs2_busy_c));
  assign in_ready  = advance_c & ~hazard_c & ~flush;
  assign fire_c    = in_valid & in_ready;

  // Source registers that are still waiting for an in-flight load result; x0 is never busy.
  always_comb begin
    rs1_busy_c = 1'b0;
    rs2_busy_c = 1'b0;
    for (int k = 0; k < int'(SB_N); k++) begin
      if (sb_vld_q[k] && (sb_rd_q[k] == in_rs1)) rs1_busy_c = 1'b1;
      if (sb_vld_q[k] && (sb_rd_q[k] == in_rs2)) rs2_busy_c = 1'b1;
    end
    if (in_rs1 == '0) rs1_busy_c = 1'b0;
    if (in_rs2 == '0) rs2_busy_c = 1'b0;
  end

  // Operand forwarding: walk oldest to youngest so the lowest index wins.
  always_comb begin
    rs1_fwd_c = rf_rs1_data;
    rs2_fwd_c = rf_rs2_data;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_wb[i] && (fwd_rd[i*REG_AW +: REG_AW] == in_rs1))
        rs1_fwd_c = fwd_data[i*XLEN +: XLEN];
      if (fwd_valid[i] && fwd_wb[i] && (fwd_rd[i*REG_AW +: REG_AW] == in_rs2))
        rs2_fwd_c = fwd_data[i*XLEN +: XLEN];
    end
    if (in_rs1 == '0) rs1_fwd_c = '0;
    if (in_rs2 == '0) rs2_fwd_c = '0;
  end

  // Scoreboard next state: shift on advance. A flush kills slot 0 because a flushed input never fires.
  always_comb begin
    for (int k = 0; k < int'(SB_N); k++) begin
      sb_vld_d[k] = sb_vld_q[k];
      sb_rd_d[k]  = sb_rd_q[k];
    end
    if (advance_c) begin
      sb_vld_d[0] = fire_c & in_is_load & in_wb & (in_rd != '0);
      sb_rd_d[0]  = in_rd;
      for (int k = 1; k < int'(SB_N); k++) begin
        sb_vld_d[k] = sb_vld_q[k-1];
        sb_rd_d[k]  = sb_rd_q[k-1];
      end
    end else if (flush) begin
      sb_vld_d[0] = 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(SB_N); k++) begin
        sb_vld_q[k] <= 1'b0;
        sb_rd_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(SB_N); k++) begin
        sb_vld_q[k] <= sb_vld_d[k];
        sb_rd_q[k]  <= sb_rd_d[k];
      end
    end
  end

  // Bubble counter: counts only cycles that really insert a bubble. It saturates at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (advance_c && hazard_c && !flush && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  // ID/EX output register: flush kills, backpressure holds, fire loads, otherwise bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
      out_wb_q    <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (advance_c) begin
      out_valid_q <= fire_c;
      if (fire_c) begin
        out_pc_q   <= in_pc;
        out_ctrl_q <= in_ctrl;
        out_rs1_q  <= rs1_fwd_c;
        out_rs2_q  <= rs2_fwd_c;
        out_rd_q   <= in_rd;
        out_wb_q   <= in_wb;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_ctrl     = out_ctrl_q;
  assign out_rs1_val  = out_rs1_q;
  assign out_rs2_val  = out_rs2_q;
  assign out_rd       = out_rd_q;
  assign out_wb       = out_wb_q;
  assign stall_cycles = stall_q;

endmodule
